nco_phase_gen: RTL

- Parametrised successor to the current sine/cosine phase generator.
- Produces a sample-rate strobe and a PHASE_W-bit phase word at OUTPUT_SAMPLE_RATE from INPUT_CLK.
- Output feeds cordic_phase or any phase-to-amplitude stage.
- Adds over the current block: power-of-two phase wrap, exact fractional-frequency correction, a handshaked tuning input with an internal sequential divider, glitch-free retune on sample boundaries, phase offset, synchronous phase clear, and a reset.

---
 rtl/nco_pkg.sv | 35 +++
 rtl/nco_ftw_div.sv | 80 ++++++++
 rtl/nco_phase_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared helpers and derived constants for the NCO phase generator.
package nco_pkg;

  // Ceiling log2. Returns 0 for v <= 1.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Dividend width: frequency word shifted left by the phase width.
  function automatic int unsigned div_width(input int unsigned freq_w, input int unsigned phase_w);
    return freq_w + phase_w;
  endfunction

  // Remainder width; one spare bit so rem + rem never overflows before the wrap test.
  function automatic int unsigned rem_width(input int unsigned rate);
    return clog2(longint'(rate)) + 1;
  endfunction

  // Strobe accumulator increment while the accumulator is negative.
  function automatic logic signed [31:0] strobe_inc_up(input int unsigned rate);
    return signed'(32'(rate));
  endfunction

  // Strobe accumulator increment on the cycle a strobe fires.
  function automatic logic signed [31:0] strobe_inc_wrap(input int unsigned rate,
                                                          input int unsigned clk_hz);
    return signed'(32'(rate)) - signed'(32'(clk_hz));
  endfunction

endpackage

// File: rtl/nco_ftw_div.sv
// Radix-2 restoring divider by a constant divisor, one quotient bit per cycle.
module nco_ftw_div
  import nco_pkg::*;
#(
  parameter int unsigned DIV_W   = 36,
  parameter int unsigned REM_W   = 14,
  parameter int unsigned DIVISOR = 8000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  output logic [DIV_W-1:0] quotient,
  output logic [REM_W-1:0] remainder,
  output logic             done
);

  localparam int unsigned     CNT_W = clog2(longint'(DIV_W) + 1);
  localparam logic [REM_W-1:0] DIV_C = REM_W'(DIVISOR);

  // quo_q starts as the dividend; its MSBs shift out while quotient bits shift in.
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic [REM_W-1:0] trial;

  // Next-state: load on start, otherwise one restoring step per cycle while running.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    // rem_q < DIVISOR, so its MSB is always zero and can be dropped by the shift.
    trial  = {rem_q[REM_W-2:0], quo_q[DIV_W-1]};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      cnt_d = CNT_W'(DIV_W);
      run_d = 1'b1;
    end else if (run_q) begin
      if (trial >= DIV_C) begin
        rem_d = trial - DIV_C;
        quo_d = {quo_q[DIV_W-2:0], 1'b1};
      end else begin
        rem_d = trial;
        quo_d = {quo_q[DIV_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider state; reset aborts any divide in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/nco_phase_gen.sv
// Sample-rate strobe plus phase accumulator with exact fractional-frequency correction.
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int unsigned INPUT_CLK          = 10000000,
  parameter int unsigned OUTPUT_SAMPLE_RATE = 8000,
  parameter int unsigned FREQ_W             = 16,
  parameter int unsigned PHASE_W            = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FREQ_W-1:0]  freq_in,
  input  logic               freq_valid,
  output logic               freq_ready,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic               sync_clr,
  output logic               sample_en,
  output logic [PHASE_W-1:0] phase_out,
  output logic               phase_valid,
  output logic               busy
);

  localparam int unsigned       DIV_W    = div_width(FREQ_W, PHASE_W);
  localparam int unsigned       REM_W    = rem_width(OUTPUT_SAMPLE_RATE);
  localparam logic signed [31:0] INC_UP   = strobe_inc_up(OUTPUT_SAMPLE_RATE);
  localparam logic signed [31:0] INC_WRAP = strobe_inc_wrap(OUTPUT_SAMPLE_RATE, INPUT_CLK);
  localparam logic [REM_W-1:0]   RATE_R   = REM_W'(OUTPUT_SAMPLE_RATE);

  logic signed [31:0] acc_q;
  logic               sample_en_q;

  logic               freq_ready_q;
  logic               pend_q;
  logic [PHASE_W-1:0] pend_ftw_q, ftw_q;
  logic [REM_W-1:0]   pend_rem_q, rem_step_q;
  logic [PHASE_W-1:0] phase_acc_q, phase_acc_d;
  logic [REM_W-1:0]   rem_acc_q, rem_acc_d;
  logic               clr_pend_q;
  logic [PHASE_W-1:0] phase_out_q;
  logic               phase_valid_q;

  logic               div_start, div_done;
  logic [DIV_W-1:0]   div_dividend, div_quo;
  logic [REM_W-1:0]   div_rem;
  logic               unused_quo_hi;

  logic               clr_now;
  logic [PHASE_W-1:0] base_phase, ftw_eff;
  logic [REM_W-1:0]   base_rem, rem_eff, rem_sum;

  // Strobe generator: Bresenham-style rate conversion from INPUT_CLK down to the sample rate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      sample_en_q <= 1'b0;
    end else begin
      acc_q       <= acc_q[31] ? acc_q + INC_UP : acc_q + INC_WRAP;
      sample_en_q <= ~acc_q[31];
    end
  end

  assign div_start    = freq_valid & freq_ready_q;
  assign div_dividend = {freq_in, {PHASE_W{1'b0}}};

  nco_ftw_div #(
    .DIV_W  (DIV_W),
    .REM_W  (REM_W),
    .DIVISOR(OUTPUT_SAMPLE_RATE)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .quotient (div_quo),
    .remainder(div_rem),
    .done     (div_done)
  );

  // Quotient bits above PHASE_W are the wrapped turns; aliasing discards them.
  assign unused_quo_hi = ^div_quo[DIV_W-1:PHASE_W];

  // Phase step for the coming strobe; a pending word and a clear both take effect in this step.
  always_comb begin
    clr_now    = clr_pend_q | sync_clr;
    base_phase = clr_now ? '0 : phase_acc_q;
    base_rem   = clr_now ? '0 : rem_acc_q;
    ftw_eff    = pend_q ? pend_ftw_q : ftw_q;
    rem_eff    = pend_q ? pend_rem_q : rem_step_q;
    rem_sum    = base_rem + rem_eff;
    if (rem_sum >= RATE_R) begin
      rem_acc_d   = rem_sum - RATE_R;
      phase_acc_d = base_phase + ftw_eff + PHASE_W'(1);
    end else begin
      rem_acc_d   = rem_sum;
      phase_acc_d = base_phase + ftw_eff;
    end
  end

  // Handshake, pending/active tuning words, accumulators and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_ready_q  <= 1'b1;
      pend_q        <= 1'b0;
      pend_ftw_q    <= '0;
      pend_rem_q    <= '0;
      ftw_q         <= '0;
      rem_step_q    <= '0;
      phase_acc_q   <= '0;
      rem_acc_q     <= '0;
      clr_pend_q    <= 1'b0;
      phase_out_q   <= '0;
      phase_valid_q <= 1'b0;
    end else begin
      phase_valid_q <= sample_en_q;
      if (div_start) begin
        freq_ready_q <= 1'b0;
      end else if (div_done) begin
        freq_ready_q <= 1'b1;
      end
      clr_pend_q <= clr_pend_q | sync_clr;
      if (sample_en_q) begin
        phase_out_q <= base_phase + phase_offset;
        phase_acc_q <= phase_acc_d;
        rem_acc_q   <= rem_acc_d;
        clr_pend_q  <= sync_clr;
        if (pend_q) begin
          ftw_q      <= pend_ftw_q;
          rem_step_q <= pend_rem_q;
          pend_q     <= 1'b0;
        end
      end
      // Written after the strobe branch so a coincident completion waits for the next strobe.
      if (div_done) begin
        pend_ftw_q <= div_quo[PHASE_W-1:0];
        pend_rem_q <= div_rem;
        pend_q     <= 1'b1;
      end
    end
  end

  assign freq_ready  = freq_ready_q;
  assign sample_en   = sample_en_q;
  assign phase_out   = phase_out_q;
  assign phase_valid = phase_valid_q;
  assign busy        = ~freq_ready_q | pend_q;

endmodule
